// File: rtl/sim_hs_ram.sv
// rtl/sim_hs_ram.sv - simulation RAM with byte strobes, valid/ready channels, programmable latency (option: SIM_HS_RAM_MISALIGN_ERR_EN)
module sim_hs_ram #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int                BYTES   = DATA_W / 8;
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0]   SPAN    = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                commit;

  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BYTES-1:0]    lat_strb;

  logic                op_write;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic [BYTES-1:0]    op_strb;
  logic [ADDR_W-1:0]   off;
  logic [IDX_W-1:0]    idx;
  logic                in_range;
  logic                misalign;
  logic                op_err;

  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // With LATENCY==1 the commit happens on the accept edge, so operands come straight from the request port
  assign op_write = (state_q == S_IDLE) ? req_write : lat_write;
  assign op_addr  = (state_q == S_IDLE) ? req_addr  : lat_addr;
  assign op_wdata = (state_q == S_IDLE) ? req_wdata : lat_wdata;
  assign op_strb  = (state_q == S_IDLE) ? req_strb  : lat_strb;

  // Offset wraps modulo 2^ADDR_W; the explicit base compare catches addresses below the window
  assign off      = op_addr - BASE_ADDR;
  assign idx      = IDX_W'(off / BYTES_A);
  assign in_range = (op_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);

`ifdef SIM_HS_RAM_MISALIGN_ERR_EN
  assign misalign = (op_addr % BYTES_A) != '0;
`else
  assign misalign = 1'b0;
`endif

  assign op_err     = !in_range || misalign;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state logic; commit marks the edge that enters RESP
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latency counter, request latch and registered response
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_strb  <= req_strb;
        cnt_q     <= CNT_W'(LATENCY - 1);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (commit) begin
        err_q   <= op_err;
        rdata_q <= (op_err || op_write) ? '0 : mem[idx];
      end
    end
  end

  // Memory array is never cleared; a reset edge suppresses any pending commit
  always_ff @(posedge clk) begin
    if (rst && commit && op_write && !op_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (op_strb[i]) mem[idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule
